// File: rtl/formal_checker_pkg.sv
// Shared types and helpers for the formal output checker: FSM state encoding
// and the sizing rule for the initialization-window skip counter.
package formal_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Must be able to hold SKIP_CYCLES itself; never narrower than one bit.
    function automatic int skip_cnt_width(input int skip_cycles);
        int w;
        w = $clog2(skip_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/formal_output_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/formal_output_checker.sv
// Compares fabric outputs against benchmark outputs on enabled samples after an initialization window.
// Optional first-error capture is enabled by defining FORMAL_CHECKER_FIRST_ERR_EN.
module formal_output_checker
    import formal_checker_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 16,
    parameter int SKIP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] gfpga_out,
    input  logic [WIDTH-1:0] bench_out,
    input  logic [WIDTH-1:0] bench_vld,
    output logic [WIDTH-1:0] mismatch,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             busy,
    output logic             pass
`ifdef FORMAL_CHECKER_FIRST_ERR_EN
    ,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_vec
`endif
);

    localparam int              SKIP_W    = skip_cnt_width(SKIP_CYCLES);
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_CYCLES);
    localparam state_t          START_ST  = (SKIP_CYCLES > 0) ? ST_SKIP : ST_CHECK;

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [WIDTH-1:0]  mismatch_n;
    logic              check_sample;
    logic              new_err;

    // start and stop both pre-empt sampling, so a stop cycle never counts a sample.
    assign mismatch_n   = (gfpga_out ^ bench_out) & bench_vld;
    assign check_sample = !start && !stop && sample_en && (state == ST_CHECK);
    assign new_err      = check_sample && (|(mismatch_n & ~mismatch));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            mismatch  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= new_err;
            if (start) begin
                state    <= START_ST;
                skip_cnt <= SKIP_INIT;
                mismatch <= '0;
            end else if (stop && (state == ST_SKIP || state == ST_CHECK)) begin
                state <= ST_DONE;
            end else if (sample_en && state == ST_SKIP) begin
                skip_cnt <= skip_cnt - SKIP_W'(1);
                if (skip_cnt <= SKIP_W'(1)) begin
                    state <= ST_CHECK;
                end
            end else if (check_sample) begin
                mismatch <= mismatch_n;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (new_err),
        .cnt   (err_count)
    );

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (check_sample),
        .cnt   (sample_count)
    );

    assign busy = (state == ST_SKIP) || (state == ST_CHECK);
    assign pass = (state == ST_DONE) && (err_count == '0);

`ifdef FORMAL_CHECKER_FIRST_ERR_EN
    // Index is the sample count before this sample's own increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_vec <= '0;
        end else if (start) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_vec <= '0;
        end else if (new_err && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= sample_count;
            first_err_vec <= mismatch_n;
        end
    end
`endif

endmodule

// File: tb/tb_formal_output_checker.sv
// Self-checking bench for formal_output_checker (WIDTH=4, CNT_W=4, SKIP_CYCLES=1) with a reference model.
module tb_formal_output_checker;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 4;
    localparam int SKIP    = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] gfpga_out = '0;
    logic [WIDTH-1:0] bench_out = '0;
    logic [WIDTH-1:0] bench_vld = '0;
    logic [WIDTH-1:0] mismatch;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;
    logic             busy;
    logic             pass;
`ifdef FORMAL_CHECKER_FIRST_ERR_EN
    logic             first_err_vld;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_vec;
`endif

    int compared = 0;
    int mismatched = 0;
    int pulse_seen = 0;

    formal_output_checker #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .SKIP_CYCLES (SKIP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .sample_en    (sample_en),
        .gfpga_out    (gfpga_out),
        .bench_out    (bench_out),
        .bench_vld    (bench_vld),
        .mismatch     (mismatch),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count),
        .busy         (busy),
        .pass         (pass)
`ifdef FORMAL_CHECKER_FIRST_ERR_EN
        ,
        .first_err_vld (first_err_vld),
        .first_err_idx (first_err_idx),
        .first_err_vec (first_err_vec)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: run phase as a small integer, counts as plain ints clipped at CNT_MAX.
    // Phase 0 idle, 1 initialization window, 2 checking, 3 finished.
    int m_phase = 0;
    int m_skip_left = 0;
    int m_err = 0;
    int m_samples = 0;
    int m_pulse = 0;
    int m_mm = 0;
    int m_first_vld = 0;
    int m_first_idx = 0;
    int m_first_vec = 0;

    always @(posedge clk or negedge rst_n) begin
        int seen;
        if (!rst_n) begin
            m_phase = 0; m_skip_left = 0; m_err = 0; m_samples = 0;
            m_pulse = 0; m_mm = 0; m_first_vld = 0; m_first_idx = 0; m_first_vec = 0;
        end else begin
            m_pulse = 0;
            if (start) begin
                m_phase = (SKIP > 0) ? 1 : 2;
                m_skip_left = SKIP;
                m_err = 0; m_samples = 0; m_mm = 0;
                m_first_vld = 0; m_first_idx = 0; m_first_vec = 0;
            end else if (stop) begin
                if (m_phase == 1 || m_phase == 2) m_phase = 3;
            end else if (sample_en && m_phase == 1) begin
                m_skip_left = m_skip_left - 1;
                if (m_skip_left == 0) m_phase = 2;
            end else if (sample_en && m_phase == 2) begin
                seen = 0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (bench_vld[i] && (gfpga_out[i] != bench_out[i])) seen |= (1 << i);
                end
                if ((seen & ~m_mm) != 0) begin
                    m_pulse = 1;
                    if (!m_first_vld) begin
                        m_first_vld = 1; m_first_idx = m_samples; m_first_vec = seen;
                    end
                    if (m_err < CNT_MAX) m_err++;
                end
                if (m_samples < CNT_MAX) m_samples++;
                m_mm = seen;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (err_pulse) pulse_seen++;
        checkOutput("mismatch", int'(mismatch), m_mm);
        checkOutput("err_pulse", int'(err_pulse), m_pulse);
        checkOutput("err_count", int'(err_count), m_err);
        checkOutput("sample_count", int'(sample_count), m_samples);
        checkOutput("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
        checkOutput("pass", int'(pass), int'(m_phase == 3 && m_err == 0));
`ifdef FORMAL_CHECKER_FIRST_ERR_EN
        checkOutput("first_err_vld", int'(first_err_vld), m_first_vld);
        checkOutput("first_err_idx", int'(first_err_idx), m_first_idx);
        checkOutput("first_err_vec", int'(first_err_vec), m_first_vec);
`endif
    end

    task automatic applyStimulus(input logic st, input logic sp, input logic se,
                                 input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] v);
        @(negedge clk);
        #1;
        start = st; stop = sp; sample_en = se;
        gfpga_out = g; bench_out = b; bench_vld = v;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset err_count", int'(err_count), 0);
        checkOutput("reset busy", int'(busy), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // 1: clean run, first sample skipped.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'h5, 4'h5, 4'hF);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t1 err_count", int'(err_count), 0);
        checkOutput("t1 sample_count", int'(sample_count), 7);
        checkOutput("t1 pass", int'(pass), 1);

        // 2: the mismatched first sample falls in the skip window.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 4'hF);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'h3, 4'h3, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t2 err_count", int'(err_count), 0);
        checkOutput("t2 mismatch", int'(mismatch), 0);
        checkOutput("t2 sample_count", int'(sample_count), 5);

        // 3: bit2 run of three, a clean sample, then one more difference.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'hF);
        pulse_seen = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t3 mismatch run", int'(mismatch), 4'b0100);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hA, 4'hA, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1110, 4'b1010, 4'hF);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t3 err_count", int'(err_count), 2);
        checkOutput("t3 pulses", pulse_seen, 2);
        checkOutput("t3 pass", int'(pass), 0);

        // 4: differing bit masked off as unknown.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'b1011);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b1011);
        idleCycle();
        @(negedge clk);
        checkOutput("t4 err_count", int'(err_count), 0);
        checkOutput("t4 mismatch", int'(mismatch), 0);

        // 5: alternating mismatch drives both counters into saturation.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'hF);
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 4'h1 : 4'h0, 4'h0, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t5 err_count sat", int'(err_count), 15);
        checkOutput("t5 sample_count sat", int'(sample_count), 15);

        // start and stop together restart rather than finish.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("start-wins busy", int'(busy), 1);
        checkOutput("start-wins err_count", int'(err_count), 0);

        // 6: errors at checked samples 5, 7, 9, then asynchronous reset mid-run.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'hF);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, (i >= 4 && i % 2 == 0) ? 4'h8 : 4'h0, 4'h0, 4'hF);
        idleCycle();
        @(negedge clk);
        checkOutput("t6 err_count", int'(err_count), 3);
`ifdef FORMAL_CHECKER_FIRST_ERR_EN
        checkOutput("t6 first_err_idx", int'(first_err_idx), 4);
        checkOutput("t6 first_err_vec", int'(first_err_vec), 8);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async err_count", int'(err_count), 0);
        checkOutput("t6 async sample_count", int'(sample_count), 0);
        checkOutput("t6 async mismatch", int'(mismatch), 0);
        checkOutput("t6 async busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) idleCycle();
        @(negedge clk);
        checkOutput("t6 idle after reset", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
